// File: rtl/vedic_mult_pipe_pkg.sv
// ---------------------------------------------------------------------------
// vedic_pkg
// Shared definitions for the pipelined Vedic multiplier:
//   VEDIC_MIN_W / VEDIC_MAX_W : legal operand width range
//   vedic_abs                 : two's complement value to unsigned magnitude
//   vedic_width_ok            : power-of-two and range check used at elaboration
// ---------------------------------------------------------------------------
package vedic_pkg;

    localparam int VEDIC_MIN_W = 4;
    localparam int VEDIC_MAX_W = 32;

    // Operates on a sign-extended VEDIC_MAX_W value, so the most negative
    // operand of any narrower width still has a representable magnitude.
    function automatic logic [VEDIC_MAX_W-1:0] vedic_abs(input logic [VEDIC_MAX_W-1:0] x);
        return x[VEDIC_MAX_W-1] ? -x : x;
    endfunction

    function automatic bit vedic_width_ok(input int w);
        return (w >= VEDIC_MIN_W) && (w <= VEDIC_MAX_W) && ((w & (w - 1)) == 0);
    endfunction

endpackage

// File: rtl/vedic_mult_pipe_if.sv
// ---------------------------------------------------------------------------
// vedic_mult_pipe_if
// Handshake bundle of the pipelined multiplier.
//   in_valid/in_ready       : operand-side handshake
//   in_a, in_b              : operands (WIDTH bits)
//   in_signed               : 1 = two's complement operands
//   in_tag                  : sideband tag returned with the product
//   out_valid/out_ready     : result-side handshake
//   out_p                   : product (2*WIDTH bits)
//   out_tag                 : tag that entered with the product
//   busy                    : any pipeline stage holds a valid entry
// slave = multiplier view, master = producer/consumer view.
// ---------------------------------------------------------------------------
interface vedic_mult_pipe_if #(
    parameter int WIDTH = 8,
    parameter int TAG_W = 4
);
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     in_a;
    logic [WIDTH-1:0]     in_b;
    logic                 in_signed;
    logic [TAG_W-1:0]     in_tag;
    logic                 out_valid;
    logic                 out_ready;
    logic [2*WIDTH-1:0]   out_p;
    logic [TAG_W-1:0]     out_tag;
    logic                 busy;

    modport slave (
        input  in_valid, in_a, in_b, in_signed, in_tag, out_ready,
        output in_ready, out_valid, out_p, out_tag, busy
    );

    modport master (
        output in_valid, in_a, in_b, in_signed, in_tag, out_ready,
        input  in_ready, out_valid, out_p, out_tag, busy
    );
endinterface

// File: rtl/vedic_mult_pipe_core.sv
// ---------------------------------------------------------------------------
// vedic_mult_core
// Combinational unsigned W x W -> 2W Urdhva-Tiryagbhyam multiplier.
//   a_i, b_i : unsigned operands (W bits, W a power of two >= 2)
//   p_o      : product (2W bits)
// Recursively splits into four W/2 cores down to a 2x2 leaf built from AND
// gates and half adders.
// ---------------------------------------------------------------------------
module vedic_mult_core #(
    parameter int W = 2
) (
    input  logic [W-1:0]   a_i,
    input  logic [W-1:0]   b_i,
    output logic [2*W-1:0] p_o
);

    if (W == 2) begin : g_leaf
        logic x_pp, y_pp, hh_pp, c1;
        assign x_pp  = a_i[1] & b_i[0];
        assign y_pp  = a_i[0] & b_i[1];
        assign hh_pp = a_i[1] & b_i[1];
        // Two half adders: cross terms, then the high term with their carry.
        assign c1    = x_pp & y_pp;
        assign p_o   = {hh_pp & c1, hh_pp ^ c1, x_pp ^ y_pp, a_i[0] & b_i[0]};
    end else begin : g_split
        localparam int H   = W / 2;
        localparam int Q4W = 2 * H + 1;
        localparam int Q5W = 3 * H;

        logic [W-1:0]   pp_ll, pp_hl, pp_lh, pp_hh;
        logic [Q4W-1:0] q4;
        logic [Q5W-1:0] q5, hi;

        vedic_mult_core #(.W(H)) u_ll (.a_i(a_i[H-1:0]), .b_i(b_i[H-1:0]), .p_o(pp_ll));
        vedic_mult_core #(.W(H)) u_hl (.a_i(a_i[W-1:H]), .b_i(b_i[H-1:0]), .p_o(pp_hl));
        vedic_mult_core #(.W(H)) u_lh (.a_i(a_i[H-1:0]), .b_i(b_i[W-1:H]), .p_o(pp_lh));
        vedic_mult_core #(.W(H)) u_hh (.a_i(a_i[W-1:H]), .b_i(b_i[W-1:H]), .p_o(pp_hh));

        // The low H bits of pp_ll are final; everything else is summed above them.
        assign q4  = Q4W'(pp_hl) + Q4W'(pp_ll[W-1:H]);
        assign q5  = Q5W'(pp_lh) + {pp_hh, {H{1'b0}}};
        assign hi  = Q5W'(q4) + q5;
        assign p_o = {hi, pp_ll[H-1:0]};
    end

endmodule

// File: rtl/vedic_mult_pipe.sv
// ---------------------------------------------------------------------------
// vedic_mult_pipe
// Four-stage pipelined Vedic multiplier for mantissa products with per-
// transaction signed/unsigned mode and a sideband tag.
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset; drops all in-flight entries
//   bus    : vedic_mult_pipe_if.slave handshake bundle
// Stages: S0 operand magnitudes + sign, S1 four half-width partial products,
// S2 first adder level, S3 final sum, conditional negate and output register.
// A single global stall freezes every stage while a result is refused.
// ---------------------------------------------------------------------------
module vedic_mult_pipe
    import vedic_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    vedic_mult_pipe_if.slave bus
);

    localparam int H   = WIDTH / 2;
    localparam int W2  = 2 * WIDTH;
    localparam int Q4W = 2 * H + 1;
    localparam int Q5W = 3 * H;

    if (!vedic_width_ok(WIDTH) || (TAG_W < 1) || (TAG_W > 16)) begin : g_param_check
        $error("vedic_mult_pipe: unsupported WIDTH=%0d or TAG_W=%0d", WIDTH, TAG_W);
    end

    logic               stall;

    logic               v0_q, neg0_q, neg0_d;
    logic [WIDTH-1:0]   a0_q, b0_q, a0_d, b0_d;
    logic [TAG_W-1:0]   tag0_q;

    logic               v1_q, neg1_q;
    logic [WIDTH-1:0]   pp_ll_q, pp_hl_q, pp_lh_q, pp_hh_q;
    logic [WIDTH-1:0]   pp_ll_d, pp_hl_d, pp_lh_d, pp_hh_d;
    logic [TAG_W-1:0]   tag1_q;

    logic               v2_q, neg2_q;
    logic [Q4W-1:0]     q4_q, q4_d;
    logic [Q5W-1:0]     q5_q, q5_d, sum_d;
    logic [H-1:0]       lo_q, lo_d;
    logic [TAG_W-1:0]   tag2_q;

    logic               out_valid_q;
    logic [W2-1:0]      out_p_q, mag_d, out_p_d;
    logic [TAG_W-1:0]   out_tag_q;

    // in_ready depends only on the output register and out_ready, never on in_valid.
    assign stall        = out_valid_q & ~bus.out_ready;
    assign bus.in_ready = ~stall;

    // Signed operands become magnitudes; sign-extending to the package width
    // first lets the most negative value map to 2^(WIDTH-1) without overflow.
    always_comb begin
        a0_d   = bus.in_a;
        b0_d   = bus.in_b;
        neg0_d = 1'b0;
        if (bus.in_signed) begin
            a0_d   = WIDTH'(vedic_abs(VEDIC_MAX_W'($signed(bus.in_a))));
            b0_d   = WIDTH'(vedic_abs(VEDIC_MAX_W'($signed(bus.in_b))));
            neg0_d = bus.in_a[WIDTH-1] ^ bus.in_b[WIDTH-1];
        end
    end

    vedic_mult_core #(.W(H)) u_core_ll (.a_i(a0_q[H-1:0]),     .b_i(b0_q[H-1:0]),     .p_o(pp_ll_d));
    vedic_mult_core #(.W(H)) u_core_hl (.a_i(a0_q[WIDTH-1:H]), .b_i(b0_q[H-1:0]),     .p_o(pp_hl_d));
    vedic_mult_core #(.W(H)) u_core_lh (.a_i(a0_q[H-1:0]),     .b_i(b0_q[WIDTH-1:H]), .p_o(pp_lh_d));
    vedic_mult_core #(.W(H)) u_core_hh (.a_i(a0_q[WIDTH-1:H]), .b_i(b0_q[WIDTH-1:H]), .p_o(pp_hh_d));

    // First adder level, then the final sum; the product always fits in 2W
    // bits, so the upper sum needs only 3H bits. Negating a zero magnitude
    // wraps back to zero.
    always_comb begin
        q4_d    = Q4W'(pp_hl_q) + Q4W'(pp_ll_q[WIDTH-1:H]);
        q5_d    = Q5W'(pp_lh_q) + {pp_hh_q, {H{1'b0}}};
        lo_d    = pp_ll_q[H-1:0];
        sum_d   = Q5W'(q4_q) + q5_q;
        mag_d   = {sum_d, lo_q};
        out_p_d = neg2_q ? -mag_d : mag_d;
    end

    // Valid bits: cleared asynchronously by reset, frozen as a group on stall
    // so bubbles keep their positions.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v0_q        <= 1'b0;
            v1_q        <= 1'b0;
            v2_q        <= 1'b0;
            out_valid_q <= 1'b0;
        end else if (!stall) begin
            v0_q        <= bus.in_valid;
            v1_q        <= v0_q;
            v2_q        <= v1_q;
            out_valid_q <= v2_q;
        end
    end

    // Stage data follows the valid bits; the output register only loads on a
    // real entry so a bubble leaves the last product and tag visible.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a0_q      <= '0;
            b0_q      <= '0;
            neg0_q    <= 1'b0;
            tag0_q    <= '0;
            pp_ll_q   <= '0;
            pp_hl_q   <= '0;
            pp_lh_q   <= '0;
            pp_hh_q   <= '0;
            neg1_q    <= 1'b0;
            tag1_q    <= '0;
            q4_q      <= '0;
            q5_q      <= '0;
            lo_q      <= '0;
            neg2_q    <= 1'b0;
            tag2_q    <= '0;
            out_p_q   <= '0;
            out_tag_q <= '0;
        end else if (!stall) begin
            a0_q      <= a0_d;
            b0_q      <= b0_d;
            neg0_q    <= neg0_d;
            tag0_q    <= bus.in_tag;
            pp_ll_q   <= pp_ll_d;
            pp_hl_q   <= pp_hl_d;
            pp_lh_q   <= pp_lh_d;
            pp_hh_q   <= pp_hh_d;
            neg1_q    <= neg0_q;
            tag1_q    <= tag0_q;
            q4_q      <= q4_d;
            q5_q      <= q5_d;
            lo_q      <= lo_d;
            neg2_q    <= neg1_q;
            tag2_q    <= tag1_q;
            if (v2_q) begin
                out_p_q   <= out_p_d;
                out_tag_q <= tag2_q;
            end
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_p     = out_p_q;
    assign bus.out_tag   = out_tag_q;
    assign bus.busy      = v0_q | v1_q | v2_q | out_valid_q;

endmodule

// File: tb/tb_vedic_mult_pipe.sv
// ---------------------------------------------------------------------------
// tb_vedic_mult_pipe
// Drives a WIDTH=8 and a WIDTH=16 instance of vedic_mult_pipe through
// directed corner cases, backpressure, mid-flight reset and a short random
// run. Expected products come from a reference multiply and are queued per
// instance when an operand pair is accepted; negedge monitors pop and compare
// each retiring result and check that a refused result holds still.
// ---------------------------------------------------------------------------
module tb_vedic_mult_pipe;

    typedef struct {
        logic [63:0] p;
        logic [3:0]  tag;
    } exp_t;

    logic clk;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;
    exp_t q8[$];
    exp_t q16[$];

    bit          held8 = 0,  held16 = 0;
    logic [15:0] hp8;
    logic [31:0] hp16;
    logic [3:0]  ht8, ht16;

    vedic_mult_pipe_if #(.WIDTH(8),  .TAG_W(4)) if8 ();
    vedic_mult_pipe_if #(.WIDTH(16), .TAG_W(4)) if16 ();

    vedic_mult_pipe #(.WIDTH(8),  .TAG_W(4)) dut8  (.clk(clk), .rst_n(rst_n), .bus(if8));
    vedic_mult_pipe #(.WIDTH(16), .TAG_W(4)) dut16 (.clk(clk), .rst_n(rst_n), .bus(if16));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case something hangs outside the bounded waits.
    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation did not finish, observed=running required=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("[TB] FAIL %s: observed=%h expected=%h", name, obs, expv);
        end
    endtask

    // Reference product: sign-interpret the operands as needed, multiply in
    // 64 bits, keep 2*w result bits.
    function automatic logic [63:0] model(input int w, input logic [31:0] a, input logic [31:0] b, input logic s);
        longint m, ua, ub, sa, sb;
        logic [63:0] r;
        m  = (longint'(1) << w) - 1;
        ua = longint'(a) & m;
        ub = longint'(b) & m;
        sa = (s && ua[w-1]) ? ua - (longint'(1) << w) : ua;
        sb = (s && ub[w-1]) ? ub - (longint'(1) << w) : ub;
        r  = 64'(sa * sb);
        if (w < 32) r = r & ((64'd1 << (2 * w)) - 64'd1);
        return r;
    endfunction

    task automatic setReady(input int w, input logic v);
        if (w == 8) if8.out_ready = v;
        else        if16.out_ready = v;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offers one pair and waits (bounded) until it is taken; the expectation
    // is queued on the cycle the transfer happens.
    task automatic applyStimulus(input int w, input logic [31:0] a, input logic [31:0] b,
                                 input logic s, input logic [3:0] tag, input bit rnd);
        exp_t e;
        bit   acc;
        int   guard;
        e.p   = model(w, a, b, s);
        e.tag = tag;
        if (w == 8) begin
            if8.in_valid = 1'b1; if8.in_a = a[7:0]; if8.in_b = b[7:0];
            if8.in_signed = s;   if8.in_tag = tag;
        end else begin
            if16.in_valid = 1'b1; if16.in_a = a[15:0]; if16.in_b = b[15:0];
            if16.in_signed = s;   if16.in_tag = tag;
        end
        acc   = 1'b0;
        guard = 0;
        while (!acc && guard < 64) begin
            @(negedge clk);
            if ((w == 8) ? if8.in_ready : if16.in_ready) begin
                acc = 1'b1;
                if (w == 8) q8.push_back(e);
                else        q16.push_back(e);
            end
            @(posedge clk);
            #1;
            if (!acc) begin
                guard++;
                if (rnd) setReady(w, 1'($urandom_range(0, 1)));
            end
        end
        if (w == 8) if8.in_valid = 1'b0;
        else        if16.in_valid = 1'b0;
        if (rnd) setReady(w, 1'($urandom_range(0, 1)));
        if (!acc) checkOutput("accept", 64'(acc), 64'd1);
    endtask

    task automatic drain(input int w);
        int g;
        setReady(w, 1'b1);
        g = 0;
        while (((w == 8) ? q8.size() : q16.size()) != 0 && g < 200) begin
            step();
            g++;
        end
        if (w == 8) begin
            checkOutput("drain8_left", 64'(q8.size()), 64'd0);
            checkOutput("drain8_busy", 64'(if8.busy), 64'd0);
        end else begin
            checkOutput("drain16_left", 64'(q16.size()), 64'd0);
            checkOutput("drain16_busy", 64'(if16.busy), 64'd0);
        end
    endtask

    // Scoreboard monitors: compare each retiring result against the oldest
    // expectation, and require a refused result to stay unchanged.
    always @(negedge clk) begin
        if (!rst_n) begin
            held8 <= 1'b0;
        end else begin
            if (held8 && if8.out_valid) begin
                checkOutput("hold8_p",   64'(if8.out_p),   64'(hp8));
                checkOutput("hold8_tag", 64'(if8.out_tag), 64'(ht8));
            end
            if (if8.out_valid && if8.out_ready) begin
                if (q8.size() == 0) checkOutput("unexpected8", 64'(q8.size()), 64'd1);
                else begin
                    checkOutput("p8",   64'(if8.out_p),   q8[0].p);
                    checkOutput("tag8", 64'(if8.out_tag), 64'(q8[0].tag));
                    void'(q8.pop_front());
                end
            end
            held8 <= if8.out_valid && !if8.out_ready;
            hp8   <= if8.out_p;
            ht8   <= if8.out_tag;
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            held16 <= 1'b0;
        end else begin
            if (held16 && if16.out_valid) begin
                checkOutput("hold16_p",   64'(if16.out_p),   64'(hp16));
                checkOutput("hold16_tag", 64'(if16.out_tag), 64'(ht16));
            end
            if (if16.out_valid && if16.out_ready) begin
                if (q16.size() == 0) checkOutput("unexpected16", 64'(q16.size()), 64'd1);
                else begin
                    checkOutput("p16",   64'(if16.out_p),   q16[0].p);
                    checkOutput("tag16", 64'(if16.out_tag), 64'(q16[0].tag));
                    void'(q16.pop_front());
                end
            end
            held16 <= if16.out_valid && !if16.out_ready;
            hp16   <= if16.out_p;
            ht16   <= if16.out_tag;
        end
    end

    initial begin
        rst_n = 1'b0;
        if8.in_valid  = 1'b0; if8.in_a  = '0; if8.in_b  = '0; if8.in_signed  = 1'b0; if8.in_tag  = '0;
        if16.in_valid = 1'b0; if16.in_a = '0; if16.in_b = '0; if16.in_signed = 1'b0; if16.in_tag = '0;
        if8.out_ready  = 1'b0;
        if16.out_ready = 1'b1;

        // Reset state, with out_ready low so in_ready must come from the cleared pipeline.
        step();
        checkOutput("rst_in_ready",  64'(if8.in_ready),  64'd1);
        checkOutput("rst_out_valid", 64'(if8.out_valid), 64'd0);
        checkOutput("rst_busy",      64'(if8.busy),      64'd0);
        checkOutput("rst_out_p",     64'(if8.out_p),     64'd0);
        checkOutput("rst_out_tag",   64'(if8.out_tag),   64'd0);
        step();
        rst_n = 1'b1;
        setReady(8, 1'b1);
        step();

        $display("[TB] unsigned maximum and latency");
        applyStimulus(8, 32'hFF, 32'hFF, 1'b0, 4'd5, 1'b0);
        step();
        checkOutput("lat_edge1", 64'(if8.out_valid), 64'd0);
        step();
        checkOutput("lat_edge2", 64'(if8.out_valid), 64'd0);
        step();
        checkOutput("lat_edge3", 64'(if8.out_valid), 64'd1);
        checkOutput("umax_p",    64'(if8.out_p),     64'hFE01);
        checkOutput("umax_tag",  64'(if8.out_tag),   64'd5);
        drain(8);

        $display("[TB] signed corners");
        applyStimulus(8, 32'h80, 32'h80, 1'b1, 4'd1, 1'b0);
        applyStimulus(8, 32'h80, 32'h7F, 1'b1, 4'd2, 1'b0);
        applyStimulus(8, 32'hFF, 32'h01, 1'b1, 4'd3, 1'b0);
        applyStimulus(8, 32'h00, 32'hFB, 1'b1, 4'd4, 1'b0);
        checkOutput("sc_first_p", 64'(if8.out_p), 64'h4000);
        step();
        checkOutput("sc_second_p", 64'(if8.out_p), 64'hC080);
        step();
        checkOutput("sc_third_p", 64'(if8.out_p), 64'hFFFF);
        step();
        checkOutput("sc_fourth_p", 64'(if8.out_p), 64'h0000);
        drain(8);

        $display("[TB] back-to-back with backpressure");
        applyStimulus(8, 32'd3,   32'd7,   1'b0, 4'd6, 1'b0);
        applyStimulus(8, 32'd200, 32'd100, 1'b0, 4'd7, 1'b0);
        applyStimulus(8, 32'hFD,  32'd5,   1'b1, 4'd8, 1'b0);
        applyStimulus(8, 32'h55,  32'hAA,  1'b1, 4'd9, 1'b0);
        setReady(8, 1'b0);
        #1;
        checkOutput("bp_in_ready",  64'(if8.in_ready),  64'd0);
        checkOutput("bp_out_valid", 64'(if8.out_valid), 64'd1);
        step(); step(); step();
        checkOutput("bp_hold_tag", 64'(if8.out_tag), 64'd6);
        checkOutput("bp_busy",     64'(if8.busy),    64'd1);
        drain(8);

        $display("[TB] mixed modes at WIDTH=16");
        applyStimulus(16, 32'hFFFF, 32'hFFFF, 1'b1, 4'd1, 1'b0);
        applyStimulus(16, 32'hFFFF, 32'hFFFF, 1'b0, 4'd2, 1'b0);
        applyStimulus(16, 32'hFFFF, 32'hFFFF, 1'b1, 4'd3, 1'b0);
        applyStimulus(16, 32'hFFFF, 32'hFFFF, 1'b0, 4'd4, 1'b0);
        checkOutput("mix_v0", 64'(if16.out_valid), 64'd1);
        checkOutput("mix_p0", 64'(if16.out_p),     64'h00000001);
        step();
        checkOutput("mix_v1", 64'(if16.out_valid), 64'd1);
        checkOutput("mix_p1", 64'(if16.out_p),     64'hFFFE0001);
        step();
        checkOutput("mix_v2", 64'(if16.out_valid), 64'd1);
        step();
        checkOutput("mix_v3", 64'(if16.out_valid), 64'd1);
        drain(16);

        $display("[TB] reset mid-flight");
        setReady(8, 1'b0);
        applyStimulus(8, 32'd11, 32'd12, 1'b0, 4'd1, 1'b0);
        applyStimulus(8, 32'd13, 32'd14, 1'b0, 4'd2, 1'b0);
        applyStimulus(8, 32'd15, 32'd16, 1'b0, 4'd3, 1'b0);
        step();
        checkOutput("mf_busy_before",  64'(if8.busy),      64'd1);
        checkOutput("mf_valid_before", 64'(if8.out_valid), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("mf_valid_async", 64'(if8.out_valid), 64'd0);
        checkOutput("mf_busy_async",  64'(if8.busy),      64'd0);
        checkOutput("mf_p_async",     64'(if8.out_p),     64'd0);
        q8.delete();
        q16.delete();
        step();
        rst_n = 1'b1;
        setReady(8, 1'b1);
        repeat (8) step();
        checkOutput("mf_busy_after",  64'(if8.busy),      64'd0);
        checkOutput("mf_valid_after", 64'(if8.out_valid), 64'd0);

        $display("[TB] random traffic");
        for (int w = 8; w <= 16; w += 8) begin
            for (int i = 0; i < 150; i++) begin
                applyStimulus(w, $urandom, $urandom, 1'($urandom_range(0, 1)),
                              4'($urandom_range(0, 15)), 1'b1);
                if ($urandom_range(0, 2) == 0) begin
                    step();
                    setReady(w, 1'($urandom_range(0, 1)));
                end
            end
            drain(w);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
